tick_scheduler: RTL

- Synchronous replacement and controller for the ripple T-flip-flop divider chain.
- A single free-running counter clocked by Clock produces a one-cycle enable pulse (Tick) at a selectable rate of Clock/2^(Sel+1). No derived clocks are used.
- A run/pause/idle FSM sequences the counter.
- A round-robin channel scheduler shares the Tick between NUM_CH consumers (for example, display digit scanning). It advances one channel per Tick.

---
 rtl/tick_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/tick_scheduler.sv
// -----------------------------------------------------------------------------
// tick_scheduler
//
// Purpose:
//   Fully synchronous rate generator and round-robin channel scheduler. A single
//   free-running counter produces a one-cycle enable pulse (Tick) every
//   2^(Sel+1) clock cycles. No derived clocks are used. A small IDLE/RUN/PAUSE
//   FSM sequences the counter. Each Tick advances a round-robin channel index
//   (Canal) over NUM_CH consumers.
//
// Ports:
//   Clock    in   1        system clock, all state on rising edge
//   Resetn   in   1        asynchronous active-low reset
//   Start    in   1        start from IDLE / resume from PAUSE
//   Stop     in   1        pause from RUN / clear from PAUSE (wins over Start)
//   Sel      in   SEL_W    rate select, period 2^(Sel+1), clamped to CNT_W-1
//   Tick     out  1        registered one-cycle enable pulse
//   Canal    out  CH_W     currently served channel index
//   ChEn     out  NUM_CH   one-hot of Canal in RUN/PAUSE, zero in IDLE
//   Running  out  1        high while in RUN
//   ClockDiv out  1        50% duty data signal (optional feature, else 0)
//
// Optional feature macro:
//   TICK_SCHED_DUTY50_EN - when defined, ClockDiv toggles on every Tick, which
//   gives a square wave of period 2^(sel_q+2). It holds in PAUSE and clears on
//   entry to IDLE. ClockDiv is a data signal only and never a clock. When the
//   macro is undefined, ClockDiv is tied to 0 and no toggle register exists.
// -----------------------------------------------------------------------------
module tick_scheduler #(
    parameter  int CNT_W  = 20,
    parameter  int NUM_CH = 4,
    parameter  int SEL_W  = 5,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Stop,
    input  logic [SEL_W-1:0]  Sel,
    output logic              Tick,
    output logic [CH_W-1:0]   Canal,
    output logic [NUM_CH-1:0] ChEn,
    output logic              Running,
    output logic              ClockDiv
);

    // FSM state encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    // Largest usable rate select: a period of 2^CNT_W fills the counter exactly
    localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONES = '1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [SEL_W-1:0]  r_sel_q;
    logic              r_tick;
    logic [CH_W-1:0]   r_canal;

    logic [SEL_W-1:0]  w_sel_eff;
    logic [CNT_W-1:0]  w_term_val;
    logic              w_at_term;
    logic              w_tick_fire;
    logic [CH_W-1:0]   w_canal_nxt;
    logic [NUM_CH-1:0] w_chen;

    // Out-of-range selects saturate rather than wrap
    assign w_sel_eff = (Sel > SEL_MAX) ? SEL_MAX : Sel;

    // Terminal value 2^(sel_q+1)-1 is a run of ones; shifting an all-ones word
    // right keeps it inside CNT_W bits even at the top setting.
    assign w_term_val = CNT_ONES >> (SEL_MAX - r_sel_q);
    assign w_at_term  = (r_cnt == w_term_val);

    // Stop has priority: a terminal edge that coincides with Stop does not fire
    assign w_tick_fire = (r_state == S_RUN) && !Stop && w_at_term;

    // Explicit wrap so non-power-of-two channel counts work
    assign w_canal_nxt = (r_canal == CH_LAST) ? '0 : (r_canal + CH_W'(1));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sel_q <= '0;
            r_tick  <= 1'b0;
            r_canal <= '0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start && !Stop) begin
                        r_cnt   <= '0;
                        r_sel_q <= w_sel_eff;
                        r_canal <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (Stop) begin
                        // cnt and Canal hold so the period resumes intact
                        r_state <= S_PAUSE;
                    end else if (w_at_term) begin
                        r_cnt   <= '0;
                        r_tick  <= 1'b1;
                        // Rate changes only land on a period boundary
                        r_sel_q <= w_sel_eff;
                        r_canal <= w_canal_nxt;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (Stop) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_canal <= '0;
                    end else if (Start) begin
                        // Resume edge only changes state; counting restarts next edge
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_canal <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_chen = '0;
        if (r_state != S_IDLE) begin
            w_chen[r_canal] = 1'b1;
        end
    end

`ifdef TICK_SCHED_DUTY50_EN
    logic r_clk_div;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_clk_div <= 1'b0;
        end else if (w_tick_fire) begin
            r_clk_div <= ~r_clk_div;
        end else if ((r_state == S_PAUSE) && Stop) begin
            // Leaving PAUSE for IDLE
            r_clk_div <= 1'b0;
        end
    end

    assign ClockDiv = r_clk_div;
`else
    assign ClockDiv = 1'b0;
`endif

    assign Tick    = r_tick;
    assign Canal   = r_canal;
    assign ChEn    = w_chen;
    assign Running = (r_state == S_RUN);

endmodule
